// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-period helper.
// UART_RX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        RX_PARITY    = 3'd3,
`endif
        RX_STOP      = 3'd4,
        RX_WAIT_IDLE = 3'd5
    } rx_state_e;

    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO, head word shown combinationally (zero when empty).
// Latency: a pushed word is visible on the cycle after the push.
// Backpressure: push while full is accepted only together with a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Extra pointer MSB separates the full case from the empty case.
    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_push_dat;
    end

    assign o_pop_dat = o_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN): mid-bit sampling into a byte FIFO.
// Latency: byte on o_valid the cycle after the stop-bit sample when the FIFO is empty.
// Backpressure: FIFO absorbs i_ready stalls; a byte arriving at a full FIFO is dropped and sets o_overrun.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 83333333,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic       o_valid,
    output logic [7:0] o_data,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun,
`ifdef UART_RX_PARITY_EN
    output logic       o_parity_err,
`endif
    input  logic       i_clr_err
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD);
    localparam int TW           = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] TMR_FULL = TW'(CLKS_PER_BIT);
    localparam logic [TW-1:0] TMR_HALF = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);

    logic          rx_meta_q, rx_sync_q;
    rx_state_e     state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          tmr_done;
    logic          push_vld, pop_vld, drop;
    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_dat;
`ifdef UART_RX_PARITY_EN
    logic          par_bad_q, par_bad_d;
    logic          par_err_q, par_err_d;
    logic          par_fail;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign tmr_done = (tmr_q <= TMR_ONE);

    always_comb begin
        state_d     = state_q;
        tmr_d       = (tmr_q != '0) ? tmr_q - TMR_ONE : tmr_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push_vld    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d   = par_bad_q;
        par_fail    = 1'b0;
`endif
        case (state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    state_d = RX_START;
                    tmr_d   = TMR_HALF;
                end
            end
            RX_START: begin
                // Line back high at mid start bit: treat as a glitch, report nothing.
                if (tmr_done) begin
                    if (!rx_sync_q) begin
                        state_d   = RX_DATA;
                        tmr_d     = TMR_FULL;
                        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        par_bad_d = 1'b0;
`endif
                    end else begin
                        state_d = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (tmr_done) begin
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    tmr_d     = TMR_FULL;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = RX_PARITY;
`else
                        state_d = RX_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                if (tmr_done) begin
                    state_d = RX_STOP;
                    tmr_d   = TMR_FULL;
                    if (^{shift_q, rx_sync_q}) begin
                        par_fail  = 1'b1;
                        par_bad_d = 1'b1;
                    end
                end
            end
`endif
            RX_STOP: begin
                if (tmr_done) begin
                    if (rx_sync_q) begin
                        state_d  = RX_IDLE;
`ifdef UART_RX_PARITY_EN
                        push_vld = !par_bad_q;
`else
                        push_vld = 1'b1;
`endif
                    end else begin
                        state_d     = RX_WAIT_IDLE;
                        frame_err_d = 1'b1;
                    end
                end
            end
            RX_WAIT_IDLE: begin
                // A held break yields a single error; wait for the line to recover.
                if (rx_sync_q) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign pop_vld   = !fifo_empty && i_ready;
    assign drop      = push_vld && fifo_full && !pop_vld;
    assign overrun_d = drop || (overrun_q && !i_clr_err);
`ifdef UART_RX_PARITY_EN
    assign par_err_d = par_fail || (par_err_q && !i_clr_err);
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= RX_IDLE;
            tmr_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q   <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q   <= par_bad_d;
            par_err_q   <= par_err_d;
`endif
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (push_vld),
        .i_push_dat (shift_q),
        .i_pop      (pop_vld),
        .o_pop_dat  (fifo_dat),
        .o_full     (fifo_full),
        .o_empty    (fifo_empty)
    );

    assign o_valid     = !fifo_empty;
    assign o_data      = fifo_dat;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = par_err_q;
`endif

endmodule
